shift_right_seq: RTL and testbench

Iterative right-shift unit for the MIPS datapath ALU stage. It executes the R-type right shifts SRL, SRA, SRLV and SRAV one bit position per clock behind a start/done handshake, complementing the left-shift path. Non-right-shift instructions pass `data_in` through unchanged, so the block can sit in series on the ALU result path.

---
 rtl/mips_funct_defs.sv | 18 +
 rtl/shift_op_decode.sv | 23 ++
 rtl/shift_right_seq.sv | 94 +++++++++
 tb/tb_shift_right_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mips_funct_defs.sv
// Shared MIPS R-type decode constants and the shift sequencer state encoding.
package mips_funct_defs;

  localparam logic [5:0] OPCODE_RTYPE = 6'h00;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shift_state_t;

endpackage

// File: rtl/shift_op_decode.sv
// Combinational decode of R-type right shifts: classification, fill mode and amount.
module shift_op_decode
  import mips_funct_defs::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] shamt,
  input  logic [4:0] rs_amount,
  output logic       is_rshift,
  output logic       arith,
  output logic [4:0] amount
);

  logic rtype;

  assign rtype     = (opcode == OPCODE_RTYPE);
  assign is_rshift = rtype && ((funct == FUNCT_SRL)  || (funct == FUNCT_SRA) ||
                               (funct == FUNCT_SRLV) || (funct == FUNCT_SRAV));
  assign arith     = is_rshift && ((funct == FUNCT_SRA) || (funct == FUNCT_SRAV));
  // funct bit 2 separates the variable forms (rs-sourced amount) from the immediate ones.
  assign amount    = funct[2] ? rs_amount : shamt;

endmodule

// File: rtl/shift_right_seq.sv
// Iterative right shifter (SRL/SRA/SRLV/SRAV), one bit per clock, start/busy/done handshake.
module shift_right_seq
  import mips_funct_defs::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  input  logic [4:0]   shamt,
  input  logic [W-1:0] rs_data,
  input  logic [W-1:0] data_in,
  output logic         busy,
  output logic         done,
  output logic         valid_op,
  output logic [W-1:0] data_out
);

  // Handshake: start is accepted only in a cycle where busy=0; every accept yields
  // exactly one single-cycle done pulse (unless reset intervenes), and data_out is
  // final while done=1 and holds until the next accept. start while busy is dropped.

  shift_state_t state, state_nx;
  logic [4:0]   cnt;
  logic         arith_q;

  logic         dec_is_rshift;
  logic         dec_arith;
  logic [4:0]   dec_amount;
  logic         unused_rs_hi;

  assign unused_rs_hi = ^rs_data[W-1:5];

  shift_op_decode u_decode (
    .opcode    (opcode),
    .funct     (funct),
    .shamt     (shamt),
    .rs_amount (rs_data[4:0]),
    .is_rshift (dec_is_rshift),
    .arith     (dec_arith),
    .amount    (dec_amount)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (!dec_is_rshift || (dec_amount == 5'd0)) state_nx = ST_DONE;
          else                                        state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt == 5'd1) state_nx = ST_DONE;
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= 5'd0;
      arith_q  <= 1'b0;
      valid_op <= 1'b0;
      data_out <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (start) begin
            data_out <= data_in;
            valid_op <= dec_is_rshift;
            arith_q  <= dec_arith;
            cnt      <= dec_amount;
          end
        end
        ST_SHIFT: begin
          data_out <= {arith_q & data_out[W-1], data_out[W-1:1]};
          cnt      <= cnt - 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Both flags decode the state register directly, so no input reaches them combinationally.
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed vector bench for shift_right_seq: table of operations plus collision and reset sequences.
module tb_shift_right_seq;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [5:0]   opcode;
  logic [5:0]   funct;
  logic [4:0]   shamt;
  logic [W-1:0] rs_data;
  logic [W-1:0] data_in;
  logic         busy;
  logic         done;
  logic         valid_op;
  logic [W-1:0] data_out;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [5:0]   opcode;
    logic [5:0]   funct;
    logic [4:0]   shamt;
    logic [W-1:0] rs_data;
    logic [W-1:0] data_in;
    logic [W-1:0] exp_out;
    logic         exp_valid;
    int           exp_lat;
  } vec_t;

  vec_t vecs[11];

  shift_right_seq #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .opcode   (opcode),
    .funct    (funct),
    .shamt    (shamt),
    .rs_data  (rs_data),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .valid_op (valid_op),
    .data_out (data_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic scramble_inputs();
    opcode  = 6'($urandom_range(0, 63));
    funct   = 6'($urandom_range(0, 63));
    shamt   = 5'($urandom_range(0, 31));
    rs_data = $urandom;
    data_in = $urandom;
  endtask

  // Drive one accept, then wait (bounded) for done. lat counts edges from the accept edge.
  task automatic run_op(input vec_t v, output int lat);
    @(negedge clk);
    opcode  = v.opcode;
    funct   = v.funct;
    shamt   = v.shamt;
    rs_data = v.rs_data;
    data_in = v.data_in;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble_inputs();
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int done_cnt;
    int first_lat;
    n_cmp = 0;
    n_bad = 0;
    start = 1'b0;
    rst_n = 1'b0;
    scramble_inputs();

    vecs[0]  = '{6'h00, 6'h02, 5'd4,  32'h0000_0000, 32'hF000_0000, 32'h0F00_0000, 1'b1, 5};
    vecs[1]  = '{6'h00, 6'h03, 5'd4,  32'h0000_0000, 32'hF000_0000, 32'hFF00_0000, 1'b1, 5};
    vecs[2]  = '{6'h00, 6'h03, 5'd31, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32};
    vecs[3]  = '{6'h00, 6'h07, 5'd9,  32'h0000_0021, 32'h8000_0001, 32'hC000_0000, 1'b1, 2};
    vecs[4]  = '{6'h00, 6'h06, 5'd9,  32'h0000_0021, 32'h8000_0001, 32'h4000_0000, 1'b1, 2};
    vecs[5]  = '{6'h00, 6'h02, 5'd0,  32'h0000_0003, 32'h1234_5678, 32'h1234_5678, 1'b1, 1};
    vecs[6]  = '{6'h00, 6'h00, 5'd4,  32'h0000_0000, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1};
    vecs[7]  = '{6'h08, 6'h02, 5'd4,  32'h0000_0000, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b0, 1};
    vecs[8]  = '{6'h00, 6'h02, 5'd31, 32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 1'b1, 32};
    vecs[9]  = '{6'h00, 6'h03, 5'd3,  32'h0000_0000, 32'h7000_0000, 32'h0E00_0000, 1'b1, 4};
    vecs[10] = '{6'h00, 6'h06, 5'd0,  32'hFFFF_FFE5, 32'hFFFF_FFFF, 32'h07FF_FFFF, 1'b1, 6};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",     W'(busy),     '0);
    check("reset_done",     W'(done),     '0);
    check("reset_valid_op", W'(valid_op), '0);
    check("reset_data_out", data_out,     '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven operations
    foreach (vecs[i]) begin
      run_op(vecs[i], lat);
      check($sformatf("v%0d_latency", i),  W'(lat),      W'(vecs[i].exp_lat));
      check($sformatf("v%0d_data_out", i), data_out,     vecs[i].exp_out);
      check($sformatf("v%0d_valid_op", i), W'(valid_op), W'(vecs[i].exp_valid));
      check($sformatf("v%0d_busy_at_done", i), W'(busy), W'(1));
      @(posedge clk); #1;
      check($sformatf("v%0d_done_one_cycle", i), W'({done, busy}), W'(0));
      check($sformatf("v%0d_data_hold", i), data_out, vecs[i].exp_out);
    end

    // Busy collision: second start during SHIFT must be dropped
    @(negedge clk);
    opcode = 6'h00; funct = 6'h03; shamt = 5'd8; rs_data = '0; data_in = 32'h8000_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble_inputs();
    done_cnt = 0;
    first_lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (done) begin
        done_cnt++;
        if (first_lat == 0) first_lat = c;
      end
      @(negedge clk);
      if (c == 2) begin
        opcode = 6'h00; funct = 6'h02; shamt = 5'd1; data_in = 32'h1234_5678;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("collide_done_count", W'(done_cnt), W'(1));
    check("collide_latency",    W'(first_lat), W'(9));
    check("collide_data_out",   data_out, 32'hFF80_0000);
    check("collide_busy_after", W'(busy), W'(0));

    // Reset in the middle of a long SRA
    @(negedge clk);
    opcode = 6'h00; funct = 6'h03; shamt = 5'd31; rs_data = '0; data_in = 32'h8000_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble_inputs();
    repeat (10) @(posedge clk);
    #1;
    check("midop_busy_before_reset", W'(busy), W'(1));
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_busy",     W'(busy),     '0);
    check("rst_data_out", data_out,     '0);
    check("rst_valid_op", W'(valid_op), '0);
    check("rst_done",     W'(done),     '0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("rst_no_stale_done", W'(done_cnt), W'(0));
    begin
      vec_t v;
      v = '{6'h00, 6'h02, 5'd1, 32'h0000_0000, 32'h0000_0002, 32'h0000_0001, 1'b1, 2};
      run_op(v, lat);
      check("post_rst_latency",  W'(lat),      W'(2));
      check("post_rst_data_out", data_out,     32'h0000_0001);
      check("post_rst_valid_op", W'(valid_op), W'(1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
